// File: rtl/key_load_controller_pkg.sv
// key_load_pkg: shared constants for the key load controller, including the
// slot index constants, the per-slot word-count table and the FSM state type.
package key_load_pkg;

    localparam int NUM_SLOTS = 6;
    localparam int SLICE_W   = 5;
    localparam int WORD_W    = 32;

    localparam logic [2:0] SLOT_PRIV = 3'd0;
    localparam logic [2:0] SLOT_Q    = 3'd1;
    localparam logic [2:0] SLOT_P    = 3'd2;
    localparam logic [2:0] SLOT_G    = 3'd3;
    localparam logic [2:0] SLOT_Y    = 3'd4;
    localparam logic [2:0] SLOT_AUX  = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ZERO
    } loadState_t;

    // Slot codes 6 and 7 do not name a key slot.
    function automatic logic isValidSlot(input logic [2:0] slot);
        return slot <= SLOT_AUX;
    endfunction

    // Number of 32-bit words that make up each key slot.
    function automatic logic [5:0] slotLength(input logic [2:0] slot);
        case (slot)
            SLOT_PRIV: return 6'd4;
            SLOT_Q:    return 6'd5;
            SLOT_P,
            SLOT_G,
            SLOT_Y,
            SLOT_AUX:  return 6'd32;
            default:   return 6'd1;
        endcase
    endfunction

endpackage

// File: rtl/key_load_controller_if.sv
// Host-side command / word stream handshake of the key load controller.
// The host is the master; the controller is the slave.
interface key_load_controller_if;
    import key_load_pkg::*;

    logic              cmdValid;
    logic              cmdReady;
    logic [2:0]        cmdKeySel;
    logic              wordValid;
    logic              wordReady;
    logic [WORD_W-1:0] wordData;
    logic              abort;

    modport master (
        output cmdValid, cmdKeySel, wordValid, wordData, abort,
        input  cmdReady, wordReady
    );

    modport slave (
        input  cmdValid, cmdKeySel, wordValid, wordData, abort,
        output cmdReady, wordReady
    );

endinterface

// File: rtl/key_load_controller_slice_counter.sv
// key_slice_counter: slice index of the word being written, cleared at the
// start of a load (or zeroize pass) and flagging the last slice of the slot.
module key_slice_counter
    import key_load_pkg::*;
(
    input  logic               clock,
    input  logic               resetN,
    input  logic               clear,
    input  logic               advance,
    input  logic [5:0]         sliceCount,
    output logic [SLICE_W-1:0] count,
    output logic               lastSlice
);

    // Slice index register; clear wins over advance.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (advance) begin
            count <= count + 1'b1;
        end
    end

    assign lastSlice = ({1'b0, count} == (sliceCount - 6'd1));

endmodule

// File: rtl/key_load_controller.sv
// key_load_controller: takes a slot-select command from the host, accepts that
// slot's word count over a valid/ready stream and turns every accepted word
// into one registered write strobe towards keyStorage.
// Optional build macro KEYLOAD_ZEROIZE_EN: an abort overwrites every slice of
// the selected slot with zero before returning to idle.
module key_load_controller
    import key_load_pkg::*;
(
    input  logic                  clock,
    input  logic                  resetN,
    key_load_controller_if.slave  host,
    output logic [WORD_W-1:0]     keyInput,
    output logic [NUM_SLOTS-1:0]  writeEnable,
    output logic [SLICE_W-1:0]    sliceSelector,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [NUM_SLOTS-1:0]  loadedMask
);

    loadState_t           state;
    loadState_t           nextState;
    logic [2:0]           slot;
    logic                 zeroing;
    logic [SLICE_W-1:0]   count;
    logic                 lastSlice;
    logic                 cmdTake;
    logic                 wordTake;
    logic                 abortTake;
    logic                 zeroStep;
    logic [NUM_SLOTS-1:0] slotMask;

    assign cmdTake   = (state == IDLE) && host.cmdValid && isValidSlot(host.cmdKeySel);
    assign abortTake = (state == LOAD) && host.abort;
    assign wordTake  = (state == LOAD) && host.wordValid && !host.abort;
    assign zeroStep  = (state == ZERO);
    assign slotMask  = NUM_SLOTS'(1) << slot;

    key_slice_counter sliceCounter (
        .clock      (clock),
        .resetN     (resetN),
        .clear      (cmdTake || abortTake),
        .advance    ((wordTake || zeroStep) && !lastSlice),
        .sliceCount (slotLength(slot)),
        .count      (count),
        .lastSlice  (lastSlice)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state selection; abort outranks a word accepted in the same cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (cmdTake) nextState = LOAD;
            LOAD: begin
                if (abortTake) begin
`ifdef KEYLOAD_ZEROIZE_EN
                    nextState = ZERO;
`else
                    nextState = IDLE;
`endif
                end else if (wordTake && lastSlice) begin
                    nextState = DONE;
                end
            end
            DONE: nextState = IDLE;
            ZERO: if (lastSlice) nextState = DONE;
            default: nextState = IDLE;
        endcase
    end

    // Handshake readiness and busy decoded from the state register.
    always_comb begin
        host.cmdReady  = (state == IDLE);
        host.wordReady = (state == LOAD);
        busy           = (state != IDLE);
    end

    // Registered keyStorage write port, status pulses and loaded-slot mask.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            keyInput      <= '0;
            writeEnable   <= '0;
            sliceSelector <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            loadedMask    <= '0;
            slot          <= '0;
            zeroing       <= 1'b0;
        end else begin
            writeEnable <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            case (state)
                IDLE: begin
                    if (host.cmdValid) begin
                        if (isValidSlot(host.cmdKeySel)) begin
                            slot                         <= host.cmdKeySel;
                            loadedMask[host.cmdKeySel]   <= 1'b0;
                            zeroing                      <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (abortTake) begin
`ifdef KEYLOAD_ZEROIZE_EN
                        zeroing <= 1'b1;
`else
                        error   <= 1'b1;
`endif
                    end else if (wordTake) begin
                        keyInput      <= host.wordData;
                        sliceSelector <= count;
                        writeEnable   <= slotMask;
                    end
                end
                DONE: begin
                    if (zeroing) begin
                        error <= 1'b1;
                    end else begin
                        done             <= 1'b1;
                        loadedMask[slot] <= 1'b1;
                    end
                end
                ZERO: begin
                    keyInput      <= '0;
                    sliceSelector <= count;
                    writeEnable   <= slotMask;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/key_load_controller.md
Name: key_load_controller

Overview:
- Sequences 32-bit key words from a host stream into the keyStorage slice-write interface (keyInput / writeEnable / sliceSelector).
- A command selects one of six key slots. The block then accepts exactly that slot's word count over a valid/ready handshake and drives one write strobe per word.
- It sits between the bus/host interface and keyStorage, and it is the only driver of keyStorage write inputs.

Parameters:
- NUM_SLOTS, 6, number of key slots; equals the writeEnable width.
- SLICE_W, 5, sliceSelector width; allows up to 32 slices of 32 bits.

Ports:
- clock  in  1  system clock, rising edge.
- resetN  in  1  asynchronous active-low reset.
- cmdValid  in  1  load command request.
- cmdReady  out  1  high only in IDLE.
- cmdKeySel  in  3  slot: 0 privateKey(4 words), 1 q(5), 2 p(32), 3 g(32), 4 y(32), 5 aux(32); 6/7 invalid.
- wordValid  in  1  key word available.
- wordReady  out  1  high in LOAD.
- wordData  in  32  key word, least-significant slice first.
- abort  in  1  cancels the current load.
- keyInput  out  32  to keyStorage.
- writeEnable  out  NUM_SLOTS  one-hot write strobe to keyStorage.
- sliceSelector  out  SLICE_W  slice index to keyStorage.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse when a load completes.
- error  out  1  one-cycle pulse on an invalid command or an abort.
- loadedMask  out  NUM_SLOTS  bit set means the slot is fully loaded.

Behaviour:
- Reset (async, resetN=0): state IDLE; keyInput=0, writeEnable=0, sliceSelector=0, done=0, error=0, loadedMask=0, internal count=0.
- All outputs are registered.
- States:
  - IDLE: cmdReady=1. On cmdValid with cmdKeySel≤5, latch the slot, set count=0, clear loadedMask[slot], go to LOAD. On cmdValid with cmdKeySel 6/7, pulse error next cycle and stay in IDLE.
  - LOAD: wordReady=1. On each accept (wordValid&&wordReady), the next cycle drives keyInput=wordData, sliceSelector=count, writeEnable=1<<slot for exactly one cycle, then count++. keyStorage captures on the following edge. With no accept, writeEnable=0 and keyInput/sliceSelector hold their last values. Sustained throughput is one word per cycle.
  - DONE: entered after the accept of word (len-1), where len is the slot's word count. Drive the final strobe, then in the next cycle pulse done=1, set loadedMask[slot], go to IDLE. wordReady=0 in DONE.
- Slot lengths are a constant table; the count never exceeds len-1.
- Abort in LOAD takes priority over a same-cycle word accept: the word is dropped and no strobe is driven. Pulse error, leave loadedMask[slot]=0, go to IDLE (or ZERO when the optional feature is compiled in).
- Abort in IDLE or DONE is ignored.
- cmdValid is ignored while busy; no queuing.
- A reset in the middle of a load drops all progress. keyStorage contents are not touched.

Optional Feature:
- KEYLOAD_ZEROIZE_EN defined: abort enters state ZERO. ZERO writes keyInput=0 to every slice 0..len-1 of the selected slot, one strobe per cycle, ignoring wordValid. It then pulses error and returns to IDLE. busy stays high throughout. A second abort during ZERO is ignored.
- Not defined: abort returns directly to IDLE, and the partial key remains in storage.

Decomposition:
- Package key_load_pkg holds: slot index constants (SLOT_PRIV..SLOT_AUX), the slot length table (4, 5, 32, 32, 32, 32), the state enum, and the word width of 32.
- Natural sub-module: key_slice_counter, a loadable slice counter with a last-slice flag compared against the slot length.

Test Plan:
- Load slot 0: cmdKeySel=0, words 0xC5F4B81A, 0x1, 0x2, 0x3 back-to-back. Required: 4 strobes with writeEnable=6'b000001 and sliceSelector 0,1,2,3; keyInput matches each word; done one cycle after the last strobe; loadedMask=6'b000001.
- Load slot 2 (p) with wordValid toggling every other cycle. Required: exactly 32 strobes with writeEnable=6'b000100, sliceSelector 0..31 in order, no strobe in idle gaps, and done pulses once.
- cmdKeySel=7. Required: one error pulse; state stays IDLE; no strobe; loadedMask unchanged.
- Abort after 3 of 5 q words. Required: error pulse and loadedMask[1]=0. With KEYLOAD_ZEROIZE_EN: five zero-writes, sliceSelector 0..4, then IDLE.
- resetN low mid-load of slot 4 (slice 10). Required: all outputs immediately reset to 0, busy=0, and a fresh load starts again at slice 0.
- Assert cmdValid while busy. Required: ignored and cmdReady=0; the current load completes normally.
